// File: rtl/keccak_rc_sequencer.sv
// keccak_rc_sequencer
// Streams the Keccak-f[1600] iota round constants RC[0..NR_ROUNDS-1], one per
// round, over a valid/ready handshake. Each constant is assembled bit by bit
// from the FIPS 202 rc(t) LFSR (one LFSR step per clock), so no constant ROM
// is needed. The LFSR keeps running from one round into the next; it is only
// reloaded when a new sequence starts. A one-cycle done pulse follows the
// acceptance of the last constant.
module keccak_rc_sequencer #(
    parameter int L         = 6,
    parameter int W         = 64,
    parameter int NR_ROUNDS = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         rc_valid,
    input  logic         rc_ready,
    output logic [W-1:0] rc_out,
    output logic [4:0]   rc_round,
    output logic         done
);

    // Bit counter j runs 0..L inside one round.
    localparam int JW = $clog2(L + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [7:0]     lfsr_r;
    logic [7:0]     lfsr_s;
    logic [JW-1:0]  j_r;
    logic [JW-1:0]  j_s;
    logic [W-1:0]   shadow_r;
    logic [W-1:0]   shadow_s;
    logic [W-1:0]   rc_out_r;
    logic [W-1:0]   rc_out_s;
    logic [4:0]     rc_round_r;
    logic [4:0]     rc_round_s;
    logic           rc_valid_r;
    logic           rc_valid_s;
    logic           busy_r;
    logic           busy_s;
    logic           done_r;
    logic           done_s;

    logic           handshake_s;
    logic           last_round_s;
    logic           gen_last_s;

    // One step of the FIPS 202 rc(t) LFSR. R[0] is the FIPS first bit; the
    // bit shifted out of R[7] feeds back into bits 0, 4, 5 and 6.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic fb;
        fb = r[7];
        return {r[6:0], 1'b0} ^ {1'b0, fb, fb, fb, 3'b000, fb};
    endfunction

    // Place rc bit b at lane position 2^j-1; every other bit is left as is.
    function automatic logic [W-1:0] place_rc_bit(input logic [W-1:0] sh,
                                                   input logic [JW-1:0] j,
                                                   input logic b);
        logic [W-1:0] res;
        res = sh;
        for (int k = 0; k <= L; k++) begin
            if (j == JW'(k)) begin
                res[(1 << k) - 1] = b;
            end else begin
                res[(1 << k) - 1] = res[(1 << k) - 1];
            end
        end
        return res;
    endfunction

    assign handshake_s  = rc_valid_r & rc_ready;
    assign last_round_s = (rc_round_r == 5'(NR_ROUNDS - 1));
    assign gen_last_s   = (j_r == JW'(L));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision; abort wins over start and over the handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_GEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (gen_last_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_GEN;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (handshake_s && last_round_s) begin
                    state_s = ST_IDLE;
                end else if (handshake_s) begin
                    state_s = ST_GEN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the LFSR, bit counter, shadow constant and outputs.
    always_comb begin
        lfsr_s     = lfsr_r;
        j_s        = j_r;
        shadow_s   = shadow_r;
        rc_out_s   = rc_out_r;
        rc_round_s = rc_round_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    lfsr_s     = 8'h01;
                    j_s        = {JW{1'b0}};
                    rc_round_s = 5'd0;
                    shadow_s   = {W{1'b0}};
                end else begin
                    lfsr_s = lfsr_r;
                end
            end
            ST_GEN: begin
                if (!abort) begin
                    shadow_s = place_rc_bit(shadow_r, j_r, lfsr_r[0]);
                    lfsr_s   = lfsr_step(lfsr_r);
                    j_s      = j_r + JW'(1);
                    // The last bit is folded in on the same edge that
                    // publishes the constant.
                    if (gen_last_s) begin
                        rc_out_s = shadow_s;
                    end else begin
                        rc_out_s = rc_out_r;
                    end
                end else begin
                    shadow_s = shadow_r;
                end
            end
            ST_HOLD: begin
                if (!abort && handshake_s) begin
                    if (last_round_s) begin
                        done_s = 1'b1;
                    end else begin
                        rc_round_s = rc_round_r + 5'd1;
                        j_s        = {JW{1'b0}};
                        shadow_s   = {W{1'b0}};
                    end
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
        rc_valid_s = (state_s == ST_HOLD);
        busy_s     = (state_s != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r     <= 8'h01;
            j_r        <= {JW{1'b0}};
            shadow_r   <= {W{1'b0}};
            rc_out_r   <= {W{1'b0}};
            rc_round_r <= 5'd0;
            rc_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            lfsr_r     <= lfsr_s;
            j_r        <= j_s;
            shadow_r   <= shadow_s;
            rc_out_r   <= rc_out_s;
            rc_round_r <= rc_round_s;
            rc_valid_r <= rc_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign busy     = busy_r;
    assign rc_valid = rc_valid_r;
    assign rc_out   = rc_out_r;
    assign rc_round = rc_round_r;
    assign done     = done_r;

endmodule

// File: tb/tb_keccak_rc_sequencer.sv
// Testbench for keccak_rc_sequencer: directed scenarios with randomized
// back-pressure, checked against a bit-level FIPS 202 rc(t) reference model.
module tb_keccak_rc_sequencer;

    localparam int L  = 6;
    localparam int W  = 64;
    localparam int NR = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         rc_ready = 1'b0;
    logic         busy;
    logic         rc_valid;
    logic [W-1:0] rc_out;
    logic [4:0]   rc_round;
    logic         done;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [63:0] exp_rc [NR];
    int          lit_idx [7] = '{0, 1, 2, 3, 5, 6, 23};
    logic [63:0] lit_val [7] = '{64'h0000000000000001, 64'h0000000000008082,
                                 64'h800000000000808A, 64'h8000000080008000,
                                 64'h0000000080000001, 64'h8000000080008081,
                                 64'h8000000080008008};

    keccak_rc_sequencer #(.L(L), .W(W), .NR_ROUNDS(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .rc_valid (rc_valid),
        .rc_ready (rc_ready),
        .rc_out   (rc_out),
        .rc_round (rc_round),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // FIPS 202 Algorithm 5, rc(t), on a 9-entry bit list.
    function automatic bit fips_rc(input int t);
        int r[9];
        int n;
        n = t % 255;
        r = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            for (int k = 8; k > 0; k--) r[k] = r[k-1];
            r[0] = 0;
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
        end
        return (r[0] != 0);
    endfunction

    // RC[ir]: bit 2^j-1 equals rc(j + 7*ir) for j = 0..L.
    function automatic logic [63:0] model_rc(input int ir);
        logic [63:0] v;
        v = 64'd0;
        for (int j = 0; j <= L; j++) v[(2**j) - 1] = fips_rc(j + 7 * ir);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rc_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid_seen"}, 64'(rc_valid), 64'd1);
    endtask

    // Consume one full sequence that has already been started.
    task automatic run_seq(input int stall_pct, input bit poke, input bit restart_in_done,
                           input string name);
        int idx, cyc, last_hs, bad_gap, early_done, not_busy;
        idx = 0; cyc = 0; last_hs = -1; bad_gap = 0; early_done = 0; not_busy = 0;
        while (idx < NR && cyc < 3000) begin
            rc_ready = ($urandom_range(99) >= stall_pct);
            if (poke) start = ($urandom_range(3) == 0);
            if (done) early_done++;
            if (!busy) not_busy++;
            if (rc_valid && rc_ready) begin
                check($sformatf("%s_rc%0d", name, idx), rc_out, exp_rc[idx]);
                check($sformatf("%s_round%0d", name, idx), 64'(rc_round), 64'(idx));
                for (int k = 0; k < 7; k++) begin
                    if (lit_idx[k] == idx)
                        check($sformatf("%s_fips_rc%0d", name, idx), rc_out, lit_val[k]);
                end
                if (last_hs >= 0 && stall_pct == 0 && (cyc - last_hs) != 8) bad_gap++;
                last_hs = cyc;
                idx++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        rc_ready = 1'b0;
        check({name, "_handshakes"}, 64'(idx), 64'(NR));
        check({name, "_early_done"}, 64'(early_done), 64'd0);
        check({name, "_busy_during"}, 64'(not_busy), 64'd0);
        if (stall_pct == 0) check({name, "_gap"}, 64'(bad_gap), 64'd0);
        check({name, "_done_pulse"}, 64'(done), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        check({name, "_valid_at_done"}, 64'(rc_valid), 64'd0);
        if (restart_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_done_once"}, 64'(done), 64'd0);
        if (restart_in_done) begin
            check({name, "_restart_busy"}, 64'(busy), 64'd1);
            check({name, "_restart_round"}, 64'(rc_round), 64'd0);
        end else begin
            check({name, "_idle_after"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int n;
        int changes;
        for (int i = 0; i < NR; i++) exp_rc[i] = model_rc(i);

        // 1. reset state and first-constant latency
        #12;
        check("rst_rc_out", rc_out, 64'd0);
        check("rst_round", 64'(rc_round), 64'd0);
        check("rst_valid", 64'(rc_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);
        rc_ready = 1'b1;
        pulse_start();
        check("t1_busy", 64'(busy), 64'd1);
        repeat (6) tick();
        check("t1_no_valid_at_6", 64'(rc_valid), 64'd0);
        tick();
        check("t1_valid_at_7", 64'(rc_valid), 64'd1);

        // 2. full run with rc_ready held high
        run_seq(0, 1'b0, 1'b0, "t2");

        // 3. hold RC[5] for 10 clocks, then release; abort afterwards
        pulse_start();
        rc_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            wait_valid("t3_pre");
            check($sformatf("t3_pre_round%0d", r), 64'(rc_round), 64'(r));
            rc_ready = 1'b1;
            tick();
            rc_ready = 1'b0;
        end
        wait_valid("t3_rc5");
        check("t3_round5", 64'(rc_round), 64'd5);
        changes = 0;
        repeat (10) begin
            tick();
            if (rc_out !== 64'h0000000080000001 || rc_round !== 5'd5 || rc_valid !== 1'b1)
                changes++;
        end
        check("t3_hold_stable", 64'(changes), 64'd0);
        check("t3_rc5_value", rc_out, 64'h0000000080000001);
        rc_ready = 1'b1;
        tick();
        rc_ready = 1'b0;
        wait_valid("t3_rc6");
        check("t3_rc6_value", rc_out, 64'h8000000080008081);
        check("t3_round6", 64'(rc_round), 64'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_busy", 64'(busy), 64'd0);
        check("t3_abort_valid", 64'(rc_valid), 64'd0);
        check("t3_abort_keep_rc", rc_out, 64'h8000000080008081);
        check("t3_abort_keep_round", 64'(rc_round), 64'd6);
        check("t3_abort_done", 64'(done), 64'd0);

        // 4. random stalls plus start pulses while busy
        pulse_start();
        run_seq(40, 1'b1, 1'b0, "t4");

        // 5. abort in round 10 GEN, restart, then async reset in HOLD
        pulse_start();
        rc_ready = 1'b1;
        n = 0;
        while (!(busy && !rc_valid && rc_round == 5'd10) && n < 500) begin
            tick();
            n++;
        end
        check("t5_reach_round10", 64'(rc_round), 64'd10);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        rc_ready = 1'b0;
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_valid", 64'(rc_valid), 64'd0);
        check("t5_abort_round", 64'(rc_round), 64'd10);
        tick();
        pulse_start();
        run_seq(0, 1'b0, 1'b0, "t5");
        pulse_start();
        wait_valid("t5_hold");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_arst_rc_out", rc_out, 64'd0);
        check("t5_arst_round", 64'(rc_round), 64'd0);
        check("t5_arst_valid", 64'(rc_valid), 64'd0);
        check("t5_arst_busy", 64'(busy), 64'd0);
        check("t5_arst_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_post_rst_done", 64'(done), 64'd0);
        check("t5_post_rst_busy", 64'(busy), 64'd0);

        // 6. start in the done cycle launches an identical second sequence
        pulse_start();
        run_seq(0, 1'b0, 1'b1, "t6a");
        run_seq(0, 1'b0, 1'b0, "t6b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
